// File: rtl/harmonic_inverse.sv
// rtl/harmonic_inverse.sv - smallest n with sum_{k=1..n} floor(2^FRAC_BITS/k) >= target
// Optional build macro: HARMINV_PERF_EN adds a 12-bit busy-cycle counter output 'cycles'.
module harmonic_inverse #(
  parameter int FRAC_BITS = 16,
  parameter int INT_BITS  = 3,
  parameter int N_W       = 4,
  localparam int SUM_W    = INT_BITS + FRAC_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SUM_W-1:0] target,
  output logic [N_W-1:0]   n,
  output logic [SUM_W-1:0] sum,
  output logic             busy,
  output logic             done,
`ifdef HARMINV_PERF_EN
  output logic [11:0]      cycles,
`endif
  output logic             overflow
);

  localparam int Q_W   = FRAC_BITS + 1;
  localparam int CNT_W = $clog2(FRAC_BITS + 2);
  localparam logic [N_W-1:0]   NMAX      = {N_W{1'b1}};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(FRAC_BITS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [N_W-1:0]   k;
  logic [N_W-1:0]   rem;
  logic [Q_W-1:0]   quo;
  logic [CNT_W-1:0] step;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] tgt;

  // The dividend 2^FRAC_BITS has a single 1 in its MSB, so only the first
  // shifted-in bit is set; the remainder always stays below k.
  logic [N_W:0]     rem_shift;
  logic [N_W:0]     k_ext;
  logic             q_bit;
  logic [N_W-1:0]   rem_next;
  logic [SUM_W-1:0] acc_next;
  logic             hit;

  // Restoring-divider step and accumulator lookahead
  always_comb begin
    rem_shift = {rem, (step == '0)};
    k_ext     = {1'b0, k};
    q_bit     = (rem_shift >= k_ext);
    rem_next  = q_bit ? N_W'(rem_shift - k_ext) : N_W'(rem_shift);
    acc_next  = acc + SUM_W'(quo);
    hit       = (acc_next >= tgt);
  end

  // Status flags decode straight from the state register
  always_comb begin
    busy = (state == S_DIV) || (state == S_ACC);
    done = (state == S_DONE);
  end

  // Control FSM, divider datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      k        <= '0;
      rem      <= '0;
      quo      <= '0;
      step     <= '0;
      acc      <= '0;
      tgt      <= '0;
      n        <= '0;
      sum      <= '0;
      overflow <= 1'b0;
`ifdef HARMINV_PERF_EN
      cycles   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            tgt      <= target;
            k        <= N_W'(1);
            acc      <= '0;
            rem      <= '0;
            step     <= '0;
            overflow <= 1'b0;
            state    <= S_DIV;
`ifdef HARMINV_PERF_EN
            cycles   <= '0;
`endif
          end
        end
        S_DIV: begin
          rem  <= rem_next;
          quo  <= {quo[Q_W-2:0], q_bit};
          step <= step + 1'b1;
`ifdef HARMINV_PERF_EN
          cycles <= cycles + 12'd1;
`endif
          if (step == LAST_STEP) state <= S_ACC;
        end
        S_ACC: begin
          acc <= acc_next;
          if (hit) begin
            n     <= k;
            sum   <= acc_next;
            state <= S_DONE;
          end else if (k == NMAX) begin
            n        <= k;
            sum      <= acc_next;
            overflow <= 1'b1;
            state    <= S_DONE;
          end else begin
            k     <= k + 1'b1;
            rem   <= '0;
            step  <= '0;
            state <= S_DIV;
`ifdef HARMINV_PERF_EN
            cycles <= cycles + 12'd1;
`endif
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_harmonic_inverse.sv
// tb/tb_harmonic_inverse.sv - self-checking bench for harmonic_inverse
module tb_harmonic_inverse;

  localparam int SUM_W = 19;
  localparam int N_W   = 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic [SUM_W-1:0] target;
  logic [N_W-1:0]   n;
  logic [SUM_W-1:0] sum;
  logic             busy;
  logic             done;
  logic             overflow;
`ifdef HARMINV_PERF_EN
  logic [11:0]      cycles;
`endif

  harmonic_inverse dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .target   (target),
    .n        (n),
    .sum      (sum),
    .busy     (busy),
    .done     (done),
`ifdef HARMINV_PERF_EN
    .cycles   (cycles),
`endif
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int prev_n   = 0;
  int prev_sum = 0;

  typedef struct {
    int tgt;
    int exp_n;
    int exp_sum;
    int exp_ovf;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the harmonic series term by term with integer division
  function automatic void model(input int t, output int mn, output int ms, output int mo);
    int s;
    s  = 0;
    mn = 15;
    mo = 1;
    for (int kk = 1; kk <= 15; kk++) begin
      s = s + (65536 / kk);
      if (s >= t) begin
        mn = kk;
        ms = s;
        mo = 0;
        return;
      end
    end
    ms = s;
  endfunction

  // One full run: start pulse, latency/busy/hold checks, results, done pulse width.
  // inject_at >= 0 re-pulses start (with target 0) that many cycles into the run.
  task automatic run(input int tgt, input int exp_n, input int exp_sum, input int exp_ovf,
                     input int inject_at, input string tag);
    int lat;
    int busy_low;
    @(negedge clk);
    start  = 1'b1;
    target = SUM_W'(tgt);
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_ovf_cleared"}, int'(overflow), 0);
    check({tag, "_n_hold"}, int'(n), prev_n);
    check({tag, "_sum_hold"}, int'(sum), prev_sum);
    lat = 0;
    busy_low = 0;
    while (!done && lat < 400) begin
      if (!busy) busy_low++;
      if (lat == inject_at) begin
        start  = 1'b1;
        target = '0;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    check({tag, "_done_seen"}, int'(done), 1);
    check({tag, "_latency"}, lat, exp_n * 18);
    check({tag, "_busy_during"}, busy_low, 0);
    check({tag, "_busy_at_done"}, int'(busy), 0);
    check({tag, "_n"}, int'(n), exp_n);
    check({tag, "_sum"}, int'(sum), exp_sum);
    check({tag, "_ovf"}, int'(overflow), exp_ovf);
`ifdef HARMINV_PERF_EN
    check({tag, "_cycles"}, int'(cycles), exp_n * 18 - 1);
`endif
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_n_after"}, int'(n), exp_n);
    check({tag, "_sum_after"}, int'(sum), exp_sum);
    check({tag, "_ovf_after"}, int'(overflow), exp_ovf);
`ifdef HARMINV_PERF_EN
    check({tag, "_cycles_hold"}, int'(cycles), exp_n * 18 - 1);
`endif
    prev_n   = exp_n;
    prev_sum = exp_sum;
  endtask

  vec_t vecs[6];

  initial begin
    int mn, ms, mo, lat, t, zero_bad;
    start  = 1'b0;
    target = '0;
    reset  = 1'b1;

    vecs[0] = '{150000, 6, 160562, 0};
    vecs[1] = '{98304, 2, 98304, 0};
    vecs[2] = '{0, 1, 65536, 0};
    vecs[3] = '{217459, 15, 217459, 0};
    vecs[4] = '{217460, 15, 217459, 1};
    vecs[5] = '{120149, 3, 120149, 0};

    // Reset then idle: everything stays at zero
    @(posedge clk);
    #1;
    reset = 1'b0;
    zero_bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (n != 0 || sum != 0 || busy || done || overflow) zero_bad++;
      @(posedge clk);
      #1;
    end
    check("reset_idle_outputs", zero_bad, 0);

    // Spec table
    for (int i = 0; i < 6; i++)
      run(vecs[i].tgt, vecs[i].exp_n, vecs[i].exp_sum, vecs[i].exp_ovf, -1, $sformatf("vec%0d", i));

    // Random targets against the reference model
    for (int i = 0; i < 16; i++) begin
      t = int'($urandom_range(0, 230000));
      model(t, mn, ms, mo);
      run(t, mn, ms, mo, -1, $sformatf("rand%0d_t%0d", i, t));
    end

    // Start re-pulsed mid-run is ignored
    run(150000, 6, 160562, 0, 40, "midstart");

    // Reset during the k=3 divide aborts and clears outputs
    @(negedge clk);
    start  = 1'b1;
    target = SUM_W'(150000);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("abort_busy_before", int'(busy), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_n", int'(n), 0);
    check("abort_sum", int'(sum), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_ovf", int'(overflow), 0);
    @(posedge clk);
    #1;
    check("abort_stays_idle", int'(busy), 0);
    prev_n   = 0;
    prev_sum = 0;
    run(120149, 3, 120149, 0, -1, "after_abort");

    // start held high across DONE is re-sampled in the following IDLE cycle
    @(negedge clk);
    start  = 1'b1;
    target = '0;
    @(posedge clk);
    lat = 0;
    while (lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    check("b2b_first_latency", lat, 18);
    @(posedge clk);
    #1;
    check("b2b_idle_busy", int'(busy), 0);
    check("b2b_idle_done", int'(done), 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_restart_busy", int'(busy), 1);
    lat = 0;
    while (!done && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b_second_latency", lat, 18);
    check("b2b_second_n", int'(n), 1);
    check("b2b_second_sum", int'(sum), 65536);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
